// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_supervisor
//  Purpose  : Reference-clock-domain supervisor for an on-board PLL. Drives the
//             PLL reset, qualifies LOCK over a stability window, releases the
//             downstream system reset once lock is stable, counts lock losses,
//             retries failed lock attempts a bounded number of times and
//             measures one PLL output against an expected edge-count range.
//  Ports    : clk        - reference clock, sole clock domain
//             rst_n      - asynchronous active-low reset
//             pll_lock   - PLL LOCK (asynchronous, synchronized here)
//             mon_clk    - PLL output under test, sampled as data (< clk/2)
//             pll_rst    - active-high PLL reset
//             sys_rst_n  - active-low reset to downstream logic
//             fault      - sticky: lock could not be achieved
//             loss_cnt   - saturating count of lock losses while running
//             freq_cnt   - mon_clk edge count of the last completed window
//             freq_valid - one-cycle pulse when freq_cnt/freq_err update
//             freq_err   - last window count outside [EXP_MIN, EXP_MAX]
//  Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES     = 12,
    parameter int unsigned LOCK_STABLE_CYCLES = 1200,
    parameter int unsigned LOCK_TIMEOUT       = 60000,
    parameter int unsigned RETRY_LIMIT        = 3,
    parameter int unsigned WINDOW_CYCLES      = 12000,
    parameter int unsigned EXP_MIN            = 990,
    parameter int unsigned EXP_MAX            = 1010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_lock,
    input  logic        mon_clk,
    output logic        pll_rst,
    output logic        sys_rst_n,
    output logic        fault,
    output logic [7:0]  loss_cnt,
    output logic [15:0] freq_cnt,
    output logic        freq_valid,
    output logic        freq_err
);

    localparam int unsigned RST_W   = $clog2(PLL_RST_CYCLES + 1);
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RTY_W   = $clog2(RETRY_LIMIT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW_CYCLES + 1);

    localparam logic [RST_W-1:0] C_RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] C_STABLE    = STB_W'(LOCK_STABLE_CYCLES);
    localparam logic [TMO_W-1:0] C_TIMEOUT   = TMO_W'(LOCK_TIMEOUT);
    localparam logic [RTY_W-1:0] C_RETRY_LIM = RTY_W'(RETRY_LIMIT);
    localparam logic [WIN_W-1:0] C_WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [15:0]      C_EXP_MIN   = 16'(EXP_MIN);
    localparam logic [15:0]      C_EXP_MAX   = 16'(EXP_MAX);

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_lock_meta;
    logic             r_lock_s;
    logic             r_mon_meta;
    logic             r_mon_s;
    logic             r_mon_d;
    logic             w_mon_edge;

    logic [RST_W-1:0] r_rst_cnt,    w_rst_cnt_next;
    logic [STB_W-1:0] r_stable_cnt, w_stable_next;
    logic [TMO_W-1:0] r_tmo_cnt,    w_tmo_next;
    logic [RTY_W-1:0] r_retry_cnt,  w_retry_next;
    logic [RTY_W-1:0] w_retry_inc;
    logic             w_loss_inc;

    logic [WIN_W-1:0] r_win_cnt;
    logic [15:0]      r_edge_cnt;
    logic [15:0]      w_edge_sum;
    logic             w_win_active;

    // Two-flop synchronizers; r_mon_d is the edge-detect history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_mon_meta  <= 1'b0;
            r_mon_s     <= 1'b0;
            r_mon_d     <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            r_mon_meta  <= mon_clk;
            r_mon_s     <= r_mon_meta;
            r_mon_d     <= r_mon_s;
        end
    end

    assign w_mon_edge  = r_mon_s & ~r_mon_d;
    assign w_retry_inc = r_retry_cnt + RTY_W'(1);

    // Next-state logic. Counters default to zero so each one starts cleared
    // whenever its state is (re)entered.
    always_comb begin
        w_state_next   = r_state;
        w_rst_cnt_next = '0;
        w_stable_next  = '0;
        w_tmo_next     = '0;
        w_retry_next   = r_retry_cnt;
        w_loss_inc     = 1'b0;
        case (r_state)
            ST_RESET_PLL: begin
                if (r_rst_cnt == C_RST_LAST) begin
                    w_state_next = ST_WAIT_LOCK;
                end else begin
                    w_rst_cnt_next = r_rst_cnt + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                w_stable_next = r_lock_s ? (r_stable_cnt + STB_W'(1)) : '0;
                w_tmo_next    = r_tmo_cnt + TMO_W'(1);
                // Stability is checked first so it wins a same-cycle tie.
                if (r_stable_cnt == C_STABLE) begin
                    w_state_next  = ST_RUN;
                    w_stable_next = '0;
                    w_tmo_next    = '0;
                end else if (r_tmo_cnt == C_TIMEOUT) begin
                    w_stable_next = '0;
                    w_tmo_next    = '0;
                    w_retry_next  = w_retry_inc;
                    w_state_next  = (w_retry_inc == C_RETRY_LIM) ? ST_FAULT
                                                                  : ST_RESET_PLL;
                end
            end
            ST_RUN: begin
                w_retry_next = '0;
                if (!r_lock_s) begin
                    w_state_next = ST_RESET_PLL;
                    w_loss_inc   = 1'b1;
                end
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_RESET_PLL;
            end
        endcase
    end

    // State, counters and registered control outputs. Outputs are decoded
    // from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RESET_PLL;
            r_rst_cnt    <= '0;
            r_stable_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_retry_cnt  <= '0;
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            fault        <= 1'b0;
            loss_cnt     <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_rst_cnt    <= w_rst_cnt_next;
            r_stable_cnt <= w_stable_next;
            r_tmo_cnt    <= w_tmo_next;
            r_retry_cnt  <= w_retry_next;
            pll_rst      <= (w_state_next == ST_RESET_PLL) ||
                            (w_state_next == ST_FAULT);
            sys_rst_n    <= (w_state_next == ST_RUN);
            fault        <= fault | (w_state_next == ST_FAULT);
            if (w_loss_inc && (loss_cnt != 8'hFF)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

    // Frequency monitor. A lock drop in RUN aborts the window in progress,
    // so the final window cycle is also suppressed when lock_s is low.
    assign w_win_active = (r_state == ST_RUN) && r_lock_s;
    assign w_edge_sum   = (r_edge_cnt == 16'hFFFF) ? 16'hFFFF
                                                   : (r_edge_cnt + {15'd0, w_mon_edge});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= 16'd0;
            freq_cnt   <= 16'd0;
            freq_err   <= 1'b0;
            freq_valid <= 1'b0;
        end else if (!w_win_active) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= 16'd0;
            freq_valid <= 1'b0;
        end else if (r_win_cnt == C_WIN_LAST) begin
            r_win_cnt  <= '0;
            r_edge_cnt <= 16'd0;
            freq_cnt   <= w_edge_sum;
            freq_err   <= (w_edge_sum < C_EXP_MIN) || (w_edge_sum > C_EXP_MAX);
            freq_valid <= 1'b1;
        end else begin
            r_win_cnt  <= r_win_cnt + WIN_W'(1);
            r_edge_cnt <= w_edge_sum;
            freq_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_lock_supervisor
//  Purpose  : Self-checking bench for pll_lock_supervisor. Stimulus pushes the
//             expected output events (cycle-stamped) into a queue; a monitor
//             detects events on the DUT outputs and pops/compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_lock = 1'b0;
    logic        mon_clk = 1'b0;
    logic        pll_rst;
    logic        sys_rst_n;
    logic        fault;
    logic [7:0]  loss_cnt;
    logic [15:0] freq_cnt;
    logic        freq_valid;
    logic        freq_err;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (16),
        .LOCK_TIMEOUT       (64),
        .RETRY_LIMIT        (3),
        .WINDOW_CYCLES      (120),
        .EXP_MIN            (9),
        .EXP_MAX            (11)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .mon_clk    (mon_clk),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .fault      (fault),
        .loss_cnt   (loss_cnt),
        .freq_cnt   (freq_cnt),
        .freq_valid (freq_valid),
        .freq_err   (freq_err)
    );

    always #5 clk = ~clk;

    // Cycle stamp: number of rising clk edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mon_clk is a pure function of the cycle stamp, period mon_per cycles.
    int mon_per = 12;
    initial forever begin
        @(negedge clk);
        mon_clk = ((cyc % mon_per) < (mon_per / 2));
    end

    localparam int K_PLL_FALL  = 0;
    localparam int K_PLL_RISE  = 1;
    localparam int K_SYS_RISE  = 2;
    localparam int K_SYS_FALL  = 3;
    localparam int K_FAULT     = 4;
    localparam int K_FREQ      = 5;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  r     = 0;
    int  c     = 0;
    int  run_at = 0;

    function automatic string kname(int k);
        case (k)
            K_PLL_FALL: return "pll_rst_fall";
            K_PLL_RISE: return "pll_rst_rise";
            K_SYS_RISE: return "sys_rst_n_rise";
            K_SYS_FALL: return "sys_rst_n_fall";
            K_FAULT:    return "fault_rise";
            default:    return "freq_valid";
        endcase
    endfunction

    task automatic push(int kind, int at, int data);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic observe(int kind, int data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got event at cycle %0d data=%0d, required no event",
                     kname(kind), cyc, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                bad++;
                $display("FAIL event_%s: got %s at cycle %0d data=%0d, required %s at cycle %0d data=%0d",
                         kname(e.kind), kname(kind), cyc, data, kname(e.kind), e.cyc, e.data);
            end
        end
    endtask

    task automatic check_drain(string name);
        check({name, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_to(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset_vals(string name);
        check({name, "_pll_rst"},    int'(pll_rst),    1);
        check({name, "_sys_rst_n"},  int'(sys_rst_n),  0);
        check({name, "_fault"},      int'(fault),      0);
        check({name, "_loss_cnt"},   int'(loss_cnt),   0);
        check({name, "_freq_cnt"},   int'(freq_cnt),   0);
        check({name, "_freq_valid"}, int'(freq_valid), 0);
        check({name, "_freq_err"},   int'(freq_err),   0);
    endtask

    task automatic do_reset(string name);
        @(negedge clk);
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        #1;
        check_reset_vals(name);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic p_pll = 1'b1;
    logic p_sys = 1'b0;
    logic p_flt = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            p_pll = 1'b1;
            p_sys = 1'b0;
            p_flt = 1'b0;
        end else begin
            if (p_pll && !pll_rst)    observe(K_PLL_FALL, 0);
            if (!p_pll && pll_rst)    observe(K_PLL_RISE, 0);
            if (!p_sys && sys_rst_n)  observe(K_SYS_RISE, 0);
            if (p_sys && !sys_rst_n)  observe(K_SYS_FALL, 0);
            if (!p_flt && fault)      observe(K_FAULT, 0);
            if (freq_valid)           observe(K_FREQ, int'({15'd0, freq_err, freq_cnt}));
            p_pll = pll_rst;
            p_sys = sys_rst_n;
            p_flt = fault;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        // Phase 1: bring-up with a one-cycle lock glitch in WAIT_LOCK, then
        // two in-range frequency windows (mon_clk period 12 -> 10 edges).
        mon_per = 12;
        do_reset("reset0");
        push(K_PLL_FALL, r + 4, 0);
        wait_to(r + 14);
        pll_lock = 1'b1;
        c = cyc;
        wait_to(c + 10);
        pll_lock = 1'b0;
        wait_to(c + 11);
        pll_lock = 1'b1;
        run_at = c + 11 + 19;
        push(K_SYS_RISE, run_at, 0);
        push(K_FREQ, run_at + 120, 10);
        push(K_FREQ, run_at + 240, 10);
        wait_to(run_at + 245);
        check("glitch_fault", int'(fault), 0);
        check("glitch_sys_rst_n", int'(sys_rst_n), 1);
        check_drain("phase1");

        // Phase 2: 256 lock losses of 5 cycles each; loss_cnt saturates.
        for (int i = 0; i < 256; i++) begin
            c = cyc;
            pll_lock = 1'b0;
            push(K_PLL_RISE, c + 3, 0);
            push(K_SYS_FALL, c + 3, 0);
            push(K_PLL_FALL, c + 7, 0);
            push(K_SYS_RISE, c + 5 + 19, 0);
            wait_to(c + 5);
            pll_lock = 1'b1;
            wait_to(c + 30);
            if (i == 0)   check("loss_cnt_first", int'(loss_cnt), 1);
            if (i == 254) check("loss_cnt_255", int'(loss_cnt), 255);
            if (i == 255) check("loss_cnt_saturated", int'(loss_cnt), 255);
        end
        check_drain("phase2");

        // Phase 3: normal bring-up, then out-of-range frequency (period 24).
        mon_per = 24;
        do_reset("reset_from_run");
        push(K_PLL_FALL, r + 4, 0);
        wait_to(r + 14);
        pll_lock = 1'b1;
        run_at = cyc + 19;
        push(K_SYS_RISE, run_at, 0);
        push(K_FREQ, run_at + 120, 5 + 65536);
        push(K_FREQ, run_at + 240, 5 + 65536);
        wait_to(run_at + 245);
        check("freq_err_sys_rst_n", int'(sys_rst_n), 1);
        check("normal_fault", int'(fault), 0);
        check_drain("phase3");

        // Phase 4: lock never rises -> three pll_rst pulses, then FAULT.
        do_reset("reset_from_run2");
        push(K_PLL_FALL, r + 4, 0);
        push(K_PLL_RISE, r + 69, 0);
        push(K_PLL_FALL, r + 73, 0);
        push(K_PLL_RISE, r + 138, 0);
        push(K_PLL_FALL, r + 142, 0);
        push(K_PLL_RISE, r + 207, 0);
        push(K_FAULT, r + 207, 0);
        wait_to(r + 407);
        check("fault_held", int'(fault), 1);
        check("fault_pll_rst", int'(pll_rst), 1);
        check("fault_sys_rst_n", int'(sys_rst_n), 0);
        check_drain("phase4");

        // Asynchronous reset between clock edges clears outputs at once.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the on-board PLL from the reference clock domain and acts as the consumer-side counterpart of the PLL wrapper. It drives the PLL reset and qualifies LOCK with a stability window. It releases a system reset only after lock is stable, counts lock losses, and retries a failed lock a bounded number of times. It also checks one PLL output against an expected edge-count range as a frequency sanity monitor.

## Interface
Parameters:
- PLL_RST_CYCLES, 12: clk cycles `pll_rst` is held after reset release or on retry (1 µs at 12 MHz).
- LOCK_STABLE_CYCLES, 1200: consecutive cycles synchronized lock must be high before `sys_rst_n` is released.
- LOCK_TIMEOUT, 60000: maximum cycles in WAIT_LOCK before a retry.
- RETRY_LIMIT, 3: number of failed lock attempts before FAULT.
- WINDOW_CYCLES, 12000: frequency measurement window.
- EXP_MIN, 990: minimum acceptable mon_clk rising edges per window.
- EXP_MAX, 1010: maximum acceptable mon_clk rising edges per window.

Ports:
- clk  in  1  reference clock (12 MHz); sole clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK; asynchronous, 2-FF synchronized internally (lock_s).
- mon_clk  in  1  PLL output under test, treated as data; must be below clk/2. It is 2-FF synchronized, then rising-edge detected.
- pll_rst  out  1  active-high PLL reset.
- sys_rst_n  out  1  active-low reset to downstream logic.
- fault  out  1  sticky; lock could not be achieved.
- loss_cnt  out  8  lock-loss events in RUN; saturates at 255.
- freq_cnt  out  16  edge count of the last completed window; saturates at 65535.
- freq_valid  out  1  one-cycle pulse when `freq_cnt` and `freq_err` update.
- freq_err  out  1  last window outside [EXP_MIN, EXP_MAX].

## Operation
- Reset values: `pll_rst` = 1, `sys_rst_n` = 0, `fault` = 0, `loss_cnt` = 0, `freq_cnt` = 0, `freq_valid` = 0, `freq_err` = 0. The state machine resets to RESET_PLL with all counters at 0.
- All outputs are registered.
- RESET_PLL:
  - `pll_rst` = 1 and `sys_rst_n` = 0 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst` = 0.
  - The stable counter increments while lock_s = 1 and clears to 0 on any lock_s = 0.
  - When the stable counter reaches LOCK_STABLE_CYCLES, go to RUN.
  - When the timeout counter reaches LOCK_TIMEOUT, increment the retry counter. If retries == RETRY_LIMIT, go to FAULT; otherwise go to RESET_PLL.
  - If stability and timeout are reached in the same cycle, stability wins.
- RUN:
  - `sys_rst_n` = 1, and the retry counter clears.
  - lock_s = 0 increments `loss_cnt` (saturating), drives `sys_rst_n` low, and moves to RESET_PLL. The measurement window is aborted with no `freq_valid`.
- FAULT:
  - `pll_rst` = 1, `sys_rst_n` = 0, `fault` = 1.
  - Exit only via `rst_n`.
- Frequency monitor:
  - Active only in RUN. The window counter and edge counter start at 0 on RUN entry.
  - At the last cycle of the window, the edge count (including an edge detected in that cycle) is latched into `freq_cnt`.
  - `freq_err` = (count < EXP_MIN) or (count > EXP_MAX).
  - `freq_valid` pulses, then both counters restart with no gap cycle.
  - `freq_err` is report-only and does not change state.
  - `freq_cnt` and `freq_err` hold their values outside RUN.
- `loss_cnt` and `fault` clear only on `rst_n`.

## Timing
- `pll_lock` to lock_s latency: 2 cycles. `mon_clk` edge to count increment: 3 cycles (2-FF synchronizer plus edge register).
- `pll_rst` falls PLL_RST_CYCLES cycles after `rst_n` deasserts or RESET_PLL is entered.
- `sys_rst_n` rises on the clock edge after the stable counter reaches LOCK_STABLE_CYCLES. That is LOCK_STABLE_CYCLES+3 cycles after the `pll_lock` rise, if the lock stays high.
- `sys_rst_n` falls 3 cycles after `pll_lock` falls in RUN. `pll_rst` rises on the same edge.
- `freq_valid` pulses once every WINDOW_CYCLES cycles in steady RUN.
- Asynchronous `rst_n` assertion at any time forces all outputs to reset values immediately.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT=64, RETRY_LIMIT=3, WINDOW_CYCLES=120, EXP_MIN=9, EXP_MAX=11.
- Normal bring-up: release `rst_n`; `pll_rst` is high for 4 cycles. Raise `pll_lock` 10 cycles later and hold it -> `sys_rst_n` rises 19 cycles after the lock rise; `fault` = 0.
- Lock glitch: in WAIT_LOCK, hold `pll_lock` high 10 cycles, low 1 cycle, then high -> the stable count restarts and `sys_rst_n` rises 19 cycles after the second rise.
- Lock loss in RUN: drop `pll_lock` for 5 cycles -> `sys_rst_n` falls 3 cycles after the drop, `pll_rst` pulses for 4 cycles, and `loss_cnt` = 1. Repeat 256 times -> `loss_cnt` stays at 255.
- Never locks: hold `pll_lock` = 0 -> exactly 3 `pll_rst` pulses, then `fault` = 1 and `pll_rst` is held at 1 until `rst_n`.
- Frequency in range: in RUN with `mon_clk` period 12 clk cycles -> `freq_valid` every 120 cycles, `freq_cnt` = 10, `freq_err` = 0.
- Frequency out of range: `mon_clk` period 24 clk cycles -> `freq_cnt` = 5, `freq_err` = 1, and `sys_rst_n` stays 1.
